// File: rtl/gvp_stream_packer.sv
// gvp_stream_packer: snapshots GVP sources on a store trigger and serializes them as a framed 32-bit AXI4-Stream
module gvp_stream_packer #(
    parameter int          NUM_SRCS     = 8,
    parameter int          SRC_MASK_LSB = 0,
    parameter logic [15:0] HDR_MARK     = 16'hFEFE,
    parameter logic [31:0] END_MARK     = 32'hEEEE_EEEE
) (
    input  logic                     a_clk,
    input  logic                     reset,
    input  logic [1:0]               store_data,
    input  logic                     store_strobe,
    input  logic [31:0]              srcs_mask,
    input  logic [NUM_SRCS*32-1:0]   src_data,
    input  logic [31:0]              index,
    input  logic [47:0]              gvp_time,
    output logic [31:0]              M_AXIS_tdata,
    output logic                     M_AXIS_tvalid,
    input  logic                     M_AXIS_tready,
    output logic                     M_AXIS_tlast,
    output logic                     stall,
    output logic                     overrun,
    output logic [31:0]              frame_count
);
    localparam int SW = NUM_SRCS > 1 ? $clog2(NUM_SRCS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_END} state_t;
    state_t              state, state_nx;
    logic [1:0]          code, hdr_cnt;
    logic [NUM_SRCS-1:0] mask, rem_mask, rem_nx, trig_mask;
    logic [31:0]         data_q [NUM_SRCS];
    logic [31:0]         index_q;
    logic [47:0]         time_q;
    logic [SW-1:0]       sel;
    logic                hs, trig, take, data_last, unused_ok;
    assign trig_mask     = srcs_mask[SRC_MASK_LSB +: NUM_SRCS];
    assign unused_ok     = ^srcs_mask;
    assign M_AXIS_tvalid = state != S_IDLE;
    assign stall         = state != S_IDLE;
    assign hs            = M_AXIS_tvalid && M_AXIS_tready;
    assign trig          = store_strobe && store_data != 2'd0;
    assign take          = trig && (state == S_IDLE || (hs && M_AXIS_tlast));
    assign rem_nx        = rem_mask & (rem_mask - NUM_SRCS'(1));
    assign data_last     = rem_nx == '0;
    always_comb begin
        sel = '0;
        for (int i = NUM_SRCS - 1; i >= 0; i--)
            if (rem_mask[i]) sel = SW'(i);
    end
    always_comb begin
        state_nx     = state;
        M_AXIS_tdata = '0;
        M_AXIS_tlast = 1'b0;
        case (state)
            S_HDR: begin
                M_AXIS_tdata = hdr_cnt == 2'd0 ? {HDR_MARK, 16'(mask)} :
                               hdr_cnt == 2'd1 ? index_q :
                               hdr_cnt == 2'd2 ? time_q[31:0] : {16'h0, time_q[47:32]};
                M_AXIS_tlast = hdr_cnt == 2'd3 && code == 2'd2 && mask == '0;
                if (hs && hdr_cnt == 2'd3)
                    state_nx = mask != '0 ? S_DATA : code == 2'd3 ? S_END : S_IDLE;
            end
            S_DATA: begin
                M_AXIS_tdata = data_q[sel];
                M_AXIS_tlast = data_last && code != 2'd3;
                if (hs && data_last) state_nx = code == 2'd3 ? S_END : S_IDLE;
            end
            S_END: begin
                M_AXIS_tdata = END_MARK;
                M_AXIS_tlast = 1'b1;
                if (hs) state_nx = S_IDLE;
            end
            default: ;
        endcase
        if (take) state_nx = store_data == 2'd1 ? (trig_mask != '0 ? S_DATA : S_IDLE) : S_HDR;
    end
    always_ff @(posedge a_clk) begin
        if (reset) begin
            state       <= S_IDLE;
            code        <= '0;
            hdr_cnt     <= '0;
            mask        <= '0;
            rem_mask    <= '0;
            index_q     <= '0;
            time_q      <= '0;
            overrun     <= 1'b0;
            frame_count <= '0;
            for (int i = 0; i < NUM_SRCS; i++) data_q[i] <= '0;
        end else begin
            state <= state_nx;
            if (trig && !take) overrun <= 1'b1;
            if (hs && M_AXIS_tlast) frame_count <= frame_count + 32'd1;
            if (take) begin
                code     <= store_data;
                mask     <= trig_mask;
                rem_mask <= trig_mask;
                hdr_cnt  <= '0;
                index_q  <= index;
                time_q   <= gvp_time;
                for (int i = 0; i < NUM_SRCS; i++) data_q[i] <= src_data[32*i +: 32];
            end else if (hs) begin
                if (state == S_HDR) hdr_cnt <= hdr_cnt + 2'd1;
                if (state == S_DATA) rem_mask <= rem_nx;
            end
        end
    end
endmodule

// File: tb/tb_gvp_stream_packer.sv
// tb_gvp_stream_packer: queue-based frame model with per-cycle compare plus literal word checks
module tb_gvp_stream_packer;
    logic         a_clk = 0, reset = 1;
    logic [1:0]   store_data = 0;
    logic         store_strobe = 0;
    logic [31:0]  srcs_mask = 0;
    logic [255:0] src_data = 0;
    logic [31:0]  index = 0;
    logic [47:0]  gvp_time = 0;
    logic [31:0]  M_AXIS_tdata;
    logic         M_AXIS_tvalid, M_AXIS_tlast, stall, overrun;
    logic         M_AXIS_tready = 1;
    logic [31:0]  frame_count;

    gvp_stream_packer dut (
        .a_clk(a_clk), .reset(reset), .store_data(store_data), .store_strobe(store_strobe),
        .srcs_mask(srcs_mask), .src_data(src_data), .index(index), .gvp_time(gvp_time),
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
        .M_AXIS_tlast(M_AXIS_tlast), .stall(stall), .overrun(overrun), .frame_count(frame_count)
    );

    always #5 a_clk = ~a_clk;

    int errs = 0, checks = 0, stall_cyc = 0;
    logic [31:0] q [$];
    logic [31:0] log_d [$];
    logic        log_l [$];
    logic        ovr = 0, m_hs, m_idle;
    logic [31:0] fc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic build_frame();
        logic [7:0] m = srcs_mask[7:0];
        if (store_data >= 2) begin
            q.push_back({16'hFEFE, 8'h00, m});
            q.push_back(index);
            q.push_back(gvp_time[31:0]);
            q.push_back({16'h0, gvp_time[47:32]});
        end
        for (int i = 0; i < 8; i++)
            if (m[i]) q.push_back(src_data[32*i +: 32]);
        if (store_data == 3) q.push_back(32'hEEEE_EEEE);
    endtask

    // model: a frame is a list of words; a trigger is taken only when the list is (about to be) empty
    always @(posedge a_clk) begin
        if (reset) begin
            q.delete();
            ovr = 0;
            fc = 0;
        end else begin
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                log_d.push_back(M_AXIS_tdata);
                log_l.push_back(M_AXIS_tlast);
            end
            m_hs = q.size() != 0 && M_AXIS_tready;
            m_idle = q.size() == 0 || (m_hs && q.size() == 1);
            if (m_hs) begin
                if (q.size() == 1) fc++;
                void'(q.pop_front());
            end
            if (store_strobe && store_data != 0) begin
                if (m_idle) build_frame();
                else ovr = 1;
            end
        end
    end

    always @(negedge a_clk) begin
        if (!reset) begin
            chk("tvalid", M_AXIS_tvalid, q.size() != 0);
            chk("stall", stall, q.size() != 0);
            if (q.size() != 0) begin
                chk("tdata", M_AXIS_tdata, q[0]);
                chk("tlast", M_AXIS_tlast, q.size() == 1);
            end
            chk("overrun", overrun, ovr);
            chk("frame_count", frame_count, fc);
            if (stall) stall_cyc++;
        end
    end

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic trig(input logic [1:0] code, input logic [31:0] m, input logic [31:0] idx, input logic [47:0] t);
        tick();
        store_strobe = 1;
        store_data = code;
        srcs_mask = m;
        index = idx;
        gvp_time = t;
        tick();
        store_strobe = 0;
        store_data = 0;
        srcs_mask = 32'hFFFF_FFFF;
        index = ~idx;
        gvp_time = ~t;
        src_data = ~src_data;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 100 && (q.size() != 0 || stall); i++) tick();
        chk(nm, {q.size() == 0, stall}, 2'b10);
    endtask

    task automatic clr();
        log_d.delete();
        log_l.delete();
        stall_cyc = 0;
    endtask

    initial begin
        repeat (3) @(posedge a_clk);
        #1;
        chk("rst_tvalid", M_AXIS_tvalid, 0);
        chk("rst_tlast", M_AXIS_tlast, 0);
        chk("rst_tdata", M_AXIS_tdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_fc", frame_count, 0);
        reset = 0;
        tick();

        clr();
        src_data = 0;
        src_data[31:0] = 32'h11;
        src_data[95:64] = 32'h33;
        trig(1, 32'h05, 0, 0);
        wait_done("t1_done");
        chk("t1_n", log_d.size(), 2);
        chk("t1_w0", log_d[0], 32'h11);
        chk("t1_w1", log_d[1], 32'h33);
        chk("t1_l", {log_l[0], log_l[1]}, 2'b01);
        chk("t1_stall", stall_cyc, 2);
        chk("t1_fc", frame_count, 1);

        clr();
        src_data = 0;
        src_data[31:0] = 32'hAA;
        trig(2, 32'h01, 7, 48'h0001_2345_6789);
        wait_done("t2_done");
        chk("t2_n", log_d.size(), 5);
        chk("t2_w0", log_d[0], 32'hFEFE_0001);
        chk("t2_w1", log_d[1], 32'h7);
        chk("t2_w2", log_d[2], 32'h2345_6789);
        chk("t2_w3", log_d[3], 32'h1);
        chk("t2_w4", log_d[4], 32'hAA);
        chk("t2_l", {log_l[0], log_l[1], log_l[2], log_l[3], log_l[4]}, 5'b00001);

        clr();
        trig(3, 32'h0, 32'h55, 48'hABCD_0000_0042);
        wait_done("t3_done");
        chk("t3_n", log_d.size(), 5);
        chk("t3_w0", log_d[0], 32'hFEFE_0000);
        chk("t3_w3", log_d[3], 32'hABCD);
        chk("t3_w4", log_d[4], 32'hEEEE_EEEE);
        chk("t3_l", {log_l[3], log_l[4]}, 2'b01);
        chk("t3_fc", frame_count, 3);

        clr();
        trig(1, 32'h0, 0, 0);
        tick();
        chk("empty_stall", stall, 0);
        chk("empty_fc", frame_count, 3);
        chk("empty_n", log_d.size(), 0);

        clr();
        src_data = 0;
        src_data[31:0] = 32'hA1;
        src_data[63:32] = 32'hA2;
        src_data[95:64] = 32'hA3;
        trig(1, 32'h07, 0, 0);
        M_AXIS_tready = 1;
        tick();
        M_AXIS_tready = 0;
        tick();
        tick();
        M_AXIS_tready = 1;
        wait_done("t4_done");
        chk("t4_n", log_d.size(), 3);
        chk("t4_w0", log_d[0], 32'hA1);
        chk("t4_w1", log_d[1], 32'hA2);
        chk("t4_w2", log_d[2], 32'hA3);
        chk("t4_stall", stall_cyc, 5);

        clr();
        src_data = 0;
        src_data[31:0] = 32'hB0;
        src_data[63:32] = 32'hB1;
        trig(1, 32'h03, 0, 0);
        src_data = 0;
        src_data[63:32] = 32'hC1;
        tick();
        store_strobe = 1;
        store_data = 1;
        srcs_mask = 32'h02;
        tick();
        store_strobe = 0;
        store_data = 0;
        wait_done("b2b_done");
        chk("b2b_n", log_d.size(), 3);
        chk("b2b_w2", log_d[2], 32'hC1);
        chk("b2b_ovr", overrun, 0);
        chk("b2b_fc", frame_count, 6);

        clr();
        src_data = 0;
        src_data[31:0] = 32'hD0;
        trig(2, 32'h01, 9, 48'h5);
        store_strobe = 1;
        store_data = 1;
        srcs_mask = 32'h01;
        tick();
        store_strobe = 0;
        store_data = 0;
        wait_done("ovr_done");
        chk("ovr_n", log_d.size(), 5);
        chk("ovr_w4", log_d[4], 32'hD0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_fc", frame_count, 7);

        clr();
        trig(2, 32'h0, 32'h21, 48'h3);
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("mid_tvalid", M_AXIS_tvalid, 0);
        chk("mid_stall", stall, 0);
        chk("mid_ovr", overrun, 0);
        chk("mid_fc", frame_count, 0);
        clr();
        trig(2, 32'h0, 32'h22, 48'h4);
        wait_done("mid_done");
        chk("mid_n", log_d.size(), 4);
        chk("mid_w0", log_d[0], 32'hFEFE_0000);
        chk("mid_w1", log_d[1], 32'h22);
        chk("mid_fc2", frame_count, 1);

        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/gvp_stream_packer.md
Name: gvp_stream_packer

Overview:
- Sits directly downstream of the GVP execution core, ahead of the AXI DMA/FIFO.
- On each GVP step strobe with a nonzero store trigger, snapshots the selected data sources, vector index and GVP time.
- Serializes the snapshot into a framed 32-bit AXI4-Stream.
- Back-pressures the GVP through its stall input while a frame is draining, so no sample is lost.

Parameters:
- NUM_SRCS, 8, number of 32-bit source channels; supported range 1..16.
- SRC_MASK_LSB, 0, bit position in srcs_mask where source-enable bit for channel 0 sits.
- HDR_MARK, 16'hFEFE, upper 16 bits of the header marker word.
- END_MARK, 32'hEEEE_EEEE, end-of-program marker word.

Ports:
- a_clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high; clears all state.
- store_data, in, 2, GVP store trigger: 0 none, 1 data, 2 header+data, 3 header+data+end.
- store_strobe, in, 1, one-cycle pulse marking a GVP step; store_data is sampled only on this cycle.
- srcs_mask, in, 32, GVP section options; bits [SRC_MASK_LSB+NUM_SRCS-1:SRC_MASK_LSB] enable channels.
- src_data, in, NUM_SRCS*32, flat source bus; channel k is bits [32k+31:32k].
- index, in, 32, GVP point index.
- gvp_time, in, 48, GVP time counter.
- M_AXIS_tdata, out, 32, stream word.
- M_AXIS_tvalid, out, 1, word valid.
- M_AXIS_tready, in, 1, downstream ready.
- M_AXIS_tlast, out, 1, last word of frame.
- stall, out, 1, high while a frame is pending; wire to GVP stall.
- overrun, out, 1, sticky; a trigger arrived while busy.
- frame_count, out, 32, frames completed (tlast handshakes).

Behaviour:
- Reset values:
  - M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0.
  - stall=0, overrun=0, frame_count=0.
  - FSM=IDLE.
- Reset mid-frame: the frame is aborted immediately; the next cycle shows tvalid=0.
- Trigger: store_strobe=1 and store_data!=0 while in IDLE.
  - Latch mask bits, all src_data, index, gvp_time and the store code into snapshot registers.
  - Later input changes do not affect the frame.
- Empty data frame: store_data=1 with zero enabled mask is accepted but produces no words. State stays IDLE, frame_count is unchanged, stall is not raised.
- FSM states: IDLE -> HDR -> DATA -> END -> IDLE.
  - HDR: entered for codes 2/3. Four words in order:
    - {HDR_MARK, 16-bit zero-extended enabled mask}
    - index
    - gvp_time[31:0]
    - {16'h0, gvp_time[47:32]}
  - DATA: one word per enabled channel, ascending channel number.
    - Next channel is the lowest set bit of the remaining-mask register, which is cleared after each accepted word.
    - No idle cycles for disabled channels.
  - END: code 3 only; emits the single word END_MARK.
  - Skip rules: empty mask goes HDR -> END (code 3) or HDR -> IDLE (code 2). Code 1 enters DATA directly.
- Latency: trigger at cycle T gives the first word valid at T+1. With tready held high, one word is accepted per cycle.
- AXI rules:
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake, except on reset.
  - tlast=1 only on the final word of each frame.
- stall = (FSM != IDLE), registered. It rises at T+1 and falls the cycle after the tlast handshake.
- Back-to-back: a trigger on the same cycle as the tlast handshake is accepted; that cycle's strobe is sampled as IDLE-equivalent.
- Overrun: any other trigger while not IDLE is dropped. overrun goes to 1 and stays set until reset; the current frame is unaffected.
- frame_count increments on each tlast handshake and wraps at 2^32-1 -> 0.

Test Plan:
- Code 1 path: srcs_mask=0x05, src0=0x11, src2=0x33, strobe with store_data=1, tready=1 -> words 0x11, 0x33; tlast on 0x33; stall high 2 cycles; frame_count=1.
- Code 2 header: mask=0x01, index=7, gvp_time=0x0001_2345_6789, src0=0xAA, store_data=2 -> 0xFEFE0001, 7, 0x23456789, 0x00000001, 0xAA; tlast on 0xAA.
- Code 3 end with empty mask: store_data=3, mask=0 -> 4 header words (first 0xFEFE0000), then 0xEEEEEEEE with tlast.
- Back-pressure: tready toggled 1,0,0,1 during a 3-word frame -> tdata stable during low tready, no word lost or duplicated, stall held until the final handshake.
- Overrun: second strobe (store_data=1) two cycles into a 5-word frame -> overrun=1, only 1 frame emitted, frame_count=1.
- Reset mid-frame: reset asserted on word 2 of 4 -> next cycle tvalid=0, stall=0, overrun=0; a new trigger then produces a full frame from word 0.
